score_keeper: RTL



---
 rtl/score_keeper.sv | 135 +++++++++++++
 1 files changed

// File: rtl/score_keeper.sv
// Aggregates dropper score lines: counts rising edges as hits, drains them into a
// BCD display score, and runs the start/play/done game flow with an end-of-song grade.
module score_keeper #(
   parameter int NUM_DROPS   = 24,
   parameter int GAME_FRAMES = 3000,
   parameter int GRADE_A     = 20,
   parameter int GRADE_B     = 10
) (
   input  logic                 frame_clk,
   input  logic                 Reset,
   input  logic [7:0]           keycode,
   input  logic [NUM_DROPS-1:0] score_vec,
   output logic [9:0]           hits,
   output logic [11:0]          score_bcd,
   output logic                 hit_pulse,
   output logic                 playing,
   output logic                 game_over,
   output logic [1:0]           grade
);

   localparam int FW = (GAME_FRAMES > 1) ? $clog2(GAME_FRAMES) : 1;
   localparam logic [FW-1:0] LAST_FRAME = FW'(GAME_FRAMES - 1);

   typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

   state_t                state, state_nxt;
   logic [NUM_DROPS-1:0]  score_prev;
   logic [FW-1:0]         frame_cnt;
   logic [9:0]            pend;
   logic [1:0]            grade_q;

   logic [NUM_DROPS-1:0]  rise_p0;
   logic [9:0]            n_p0;
   logic [9:0]            hits_nxt;
   logic                  start;
   logic                  drain_en;
   logic                  bcd_sat;

   function automatic logic [9:0] popcount(input logic [NUM_DROPS-1:0] v);
      logic [9:0] c;
      c = '0;
      for (int i = 0; i < NUM_DROPS; i++) c = c + 10'(v[i]);
      return c;
   endfunction

   function automatic logic [9:0] sat_hits(input logic [9:0] h, input logic [9:0] n);
      logic [10:0] s;
      s = {1'b0, h} + {1'b0, n};
      return (s > 11'd999) ? 10'd999 : s[9:0];
   endfunction

   function automatic logic [11:0] bcd_inc(input logic [11:0] b);
      logic [3:0] d0, d1, d2;
      {d2, d1, d0} = b;
      if (b == 12'h999) return b;
      if (d0 != 4'd9) begin
         d0 = d0 + 4'd1;
      end else begin
         d0 = 4'd0;
         if (d1 != 4'd9) begin
            d1 = d1 + 4'd1;
         end else begin
            d1 = 4'd0;
            d2 = d2 + 4'd1;
         end
      end
      return {d2, d1, d0};
   endfunction

   function automatic logic [1:0] grade_of(input logic [9:0] h);
      if (int'(h) >= GRADE_A)      return 2'd3;
      else if (int'(h) >= GRADE_B) return 2'd2;
      else if (h != 10'd0)         return 2'd1;
      else                         return 2'd0;
   endfunction

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (keycode == 8'h2c) state_nxt = PLAY;
         PLAY:    if (frame_cnt == LAST_FRAME) state_nxt = DONE;
         DONE:    if (keycode == 8'h01) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Stage p0: edge detect and hit arithmetic, only live while playing
   always_comb begin
      rise_p0  = score_vec & ~score_prev;
      n_p0     = (state == PLAY) ? popcount(rise_p0) : 10'd0;
      hits_nxt = sat_hits(hits, n_p0);
      start    = (state == IDLE) && (state_nxt == PLAY);
      drain_en = (pend != 10'd0);
      bcd_sat  = (score_bcd == 12'h999);
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state      <= IDLE;
         hits       <= '0;
         score_bcd  <= '0;
         pend       <= '0;
         frame_cnt  <= '0;
         score_prev <= '0;
         hit_pulse  <= 1'b0;
         grade_q    <= 2'd0;
      end else begin
         state      <= state_nxt;
         score_prev <= score_vec;
         hit_pulse  <= (n_p0 != 10'd0);
         if (start) begin
            hits      <= '0;
            score_bcd <= '0;
            pend      <= '0;
            frame_cnt <= '0;
            grade_q   <= 2'd0;
         end else begin
            if (state == PLAY) begin
               hits <= hits_nxt;
               if (frame_cnt != LAST_FRAME) frame_cnt <= frame_cnt + 1'b1;
               if (state_nxt == DONE) grade_q <= grade_of(hits_nxt);
            end
            // Once the display is pinned at 999 any backlog can never be shown
            if (bcd_sat) pend <= '0;
            else         pend <= pend + n_p0 - {9'd0, drain_en};
            if (drain_en) score_bcd <= bcd_inc(score_bcd);
         end
      end
   end

   assign playing   = (state == PLAY);
   assign game_over = (state == DONE);
   assign grade     = (state == DONE) ? grade_q : 2'd0;

endmodule
